// File: rtl/instr_op_pkg.sv
// Shared op encodings and stage types for the branch execution unit.
// The beu_op_e values are the select_i encodings driven by the decoder.
package instr_op;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    BEU_JAL  = 3'd0,
    BEU_JALR = 3'd1,
    BEU_BEQ  = 3'd2,
    BEU_BNE  = 3'd3,
    BEU_BLT  = 3'd4,
    BEU_BGE  = 3'd5,
    BEU_BLTU = 3'd6,
    BEU_BGEU = 3'd7
  } beu_op_e;

  // Control half of the first pipeline stage; the XLEN-wide sums live
  // next to it in the top module because a package cannot be parametrised.
  typedef struct packed {
    logic    valid;
    beu_op_e op;
    logic    eq;
    logic    lt;
    logic    ltu;
    logic    pred_taken;
  } beu_s1_ctrl_t;

  function automatic logic is_jump(input beu_op_e op);
    return (op == BEU_JAL) || (op == BEU_JALR);
  endfunction

  function automatic logic resolve_taken(input beu_op_e op, input logic eq,
                                         input logic lt, input logic ltu);
    logic taken;
    taken = 1'b0;
    case (op)
      BEU_JAL:  taken = 1'b1;
      BEU_JALR: taken = 1'b1;
      BEU_BEQ:  taken = eq;
      BEU_BNE:  taken = !eq;
      BEU_BLT:  taken = lt;
      BEU_BGE:  taken = !lt;
      BEU_BLTU: taken = ltu;
      BEU_BGEU: taken = !ltu;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/beu_cmp.sv
// Combinational operand comparator: equality, signed and unsigned less-than.
module beu_cmp #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  // All three flags come straight from the operands with no state.
  always_comb begin
    eq  = (op1 == op2);
    lt  = ($signed(op1) < $signed(op2));
    ltu = (op1 < op2);
  end

endmodule

// File: rtl/branch_exec_unit.sv
// Two-stage branch/jump execution unit with valid/ready on both sides.
// Stage 1 captures compare flags and the candidate sums; stage 2 holds the
// resolved result until the consumer takes it.
// Optional feature: define BEU_RVC_EN to add is_rvc_i (compressed
// instructions use pc+2 for link/fall-through, misalignment is never flagged).
module branch_exec_unit
  import instr_op::*;
#(
  parameter int XLEN  = 64,
  parameter int IMM_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [SEL_W-1:0] select_i,
  input  logic [XLEN-1:0]  op1_i,
  input  logic [XLEN-1:0]  op2_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
`ifdef BEU_RVC_EN
  input  logic             is_rvc_i,
`endif
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             taken_o,
  output logic [XLEN-1:0]  target_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [XLEN-1:0]  link_o,
  output logic             link_we_o,
  output logic             mispredict_o,
  output logic             misalign_o
);

  logic            cmp_eq;
  logic            cmp_lt;
  logic            cmp_ltu;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] fall_inc;

  beu_s1_ctrl_t    s1_ctrl;
  logic [XLEN-1:0] s1_pc_imm;
  logic [XLEN-1:0] s1_op1_imm;
  logic [XLEN-1:0] s1_fall;
  logic [XLEN-1:0] s1_pred_target;

  logic            s2_valid;
  logic            s2_taken;
  logic [XLEN-1:0] s2_target;
  logic [XLEN-1:0] s2_redirect;
  logic [XLEN-1:0] s2_link;
  logic            s2_link_we;
  logic            s2_mispredict;
  logic            s2_misalign;

  logic            s2_advance;
  logic            accept;

  logic            res_taken;
  logic            res_jump;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_redirect;
  logic [XLEN-1:0] res_link;
  logic            res_link_we;
  logic            res_mispredict;
  logic            res_misalign;

  beu_cmp #(.XLEN(XLEN)) u_cmp (
    .op1 (op1_i),
    .op2 (op2_i),
    .eq  (cmp_eq),
    .lt  (cmp_lt),
    .ltu (cmp_ltu)
  );

  assign imm_sext = {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};

`ifdef BEU_RVC_EN
  assign fall_inc = is_rvc_i ? XLEN'(2) : XLEN'(4);
`else
  assign fall_inc = XLEN'(4);
`endif

  // Stage 1 moves whenever stage 2 is empty or draining, so a full
  // pipeline with ready_i high still takes one request per cycle.
  always_comb begin
    s2_advance = !s2_valid || ready_i;
    ready_o    = !s1_ctrl.valid || s2_advance;
    accept     = valid_i && ready_o;
  end

  // Stage 1 register: flags and all candidate addresses for the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ctrl        <= '0;
      s1_pc_imm      <= '0;
      s1_op1_imm     <= '0;
      s1_fall        <= '0;
      s1_pred_target <= '0;
    end else begin
      if (flush_i) begin
        s1_ctrl.valid <= 1'b0;
      end else if (ready_o) begin
        s1_ctrl.valid <= valid_i;
      end
      if (accept) begin
        s1_ctrl.op         <= beu_op_e'(select_i);
        s1_ctrl.eq         <= cmp_eq;
        s1_ctrl.lt         <= cmp_lt;
        s1_ctrl.ltu        <= cmp_ltu;
        s1_ctrl.pred_taken <= pred_taken_i;
        s1_pc_imm          <= pc_i + imm_sext;
        s1_op1_imm         <= op1_i + imm_sext;
        s1_fall            <= pc_i + fall_inc;
        s1_pred_target     <= pred_target_i;
      end
    end
  end

  // Resolve direction, target, link and prediction check from stage 1.
  always_comb begin
    res_taken      = 1'b0;
    res_jump       = 1'b0;
    res_target     = '0;
    res_redirect   = '0;
    res_link       = '0;
    res_link_we    = 1'b0;
    res_mispredict = 1'b0;
    res_misalign   = 1'b0;

    res_taken    = resolve_taken(s1_ctrl.op, s1_ctrl.eq, s1_ctrl.lt, s1_ctrl.ltu);
    res_jump     = is_jump(s1_ctrl.op);
    res_target   = (s1_ctrl.op == BEU_JALR) ? (s1_op1_imm & ~XLEN'(1)) : s1_pc_imm;
    res_redirect = res_taken ? res_target : s1_fall;
    res_link     = res_jump ? s1_fall : '0;
    res_link_we  = res_jump;
`ifdef BEU_RVC_EN
    res_misalign = 1'b0;
`else
    res_misalign = res_taken && res_target[1];
`endif
    res_mispredict = (res_taken != s1_ctrl.pred_taken) ||
                     (res_taken && (res_target != s1_pred_target));
    if (res_misalign) begin
      res_mispredict = 1'b0;
      res_link_we    = 1'b0;
    end
  end

  // Stage 2 register: holds the resolved result steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      s2_taken      <= 1'b0;
      s2_target     <= '0;
      s2_redirect   <= '0;
      s2_link       <= '0;
      s2_link_we    <= 1'b0;
      s2_mispredict <= 1'b0;
      s2_misalign   <= 1'b0;
    end else begin
      if (flush_i) begin
        s2_valid <= 1'b0;
      end else if (s2_advance) begin
        s2_valid <= s1_ctrl.valid;
      end
      if (s2_advance && s1_ctrl.valid) begin
        s2_taken      <= res_taken;
        s2_target     <= res_target;
        s2_redirect   <= res_redirect;
        s2_link       <= res_link;
        s2_link_we    <= res_link_we;
        s2_mispredict <= res_mispredict;
        s2_misalign   <= res_misalign;
      end
    end
  end

  assign valid_o       = s2_valid;
  assign taken_o       = s2_taken;
  assign target_o      = s2_target;
  assign redirect_pc_o = s2_redirect;
  assign link_o        = s2_link;
  assign link_we_o     = s2_link_we;
  assign mispredict_o  = s2_mispredict;
  assign misalign_o    = s2_misalign;

endmodule

// File: doc/branch_exec_unit.md
BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning operand/PC width.
REQ-002 SHALL have parameter IMM_W, default 21, meaning signed immediate width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid_i  input  1  request valid.
REQ-006 SHALL have port ready_o  output  1  unit accepts request this cycle.
REQ-007 SHALL have port select_i  input  3  op code: JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU.
REQ-008 SHALL have ports op1_i, op2_i  input  XLEN  rs1/rs2 values.
REQ-009 SHALL have ports pc_i  input  XLEN and imm_i  input  IMM_W  instruction PC and signed offset.
REQ-010 SHALL have ports pred_taken_i  input  1 and pred_target_i  input  XLEN  front-end prediction.
REQ-011 SHALL have port flush_i  input  1  kill all in-flight entries.
REQ-012 SHALL have ports valid_o  output  1 and ready_i  input  1  result handshake.
REQ-013 SHALL have ports taken_o 1, target_o XLEN, redirect_pc_o XLEN, link_o XLEN, link_we_o 1, mispredict_o 1, misalign_o 1, all outputs.

Function
REQ-014 SHALL transfer a request when valid_i && ready_o, and a result when valid_o && ready_i.
REQ-015 SHALL be a 2-stage pipeline: S1 registers compare flags, sum pc_i+sext(imm_i), op1_i+sext(imm_i), pc_i+4; S2 registers resolved outputs; latency exactly 2 cycles with ready_i held high.
REQ-016 SHALL drive ready_o = !S1.valid || S1 advances; S1 advances when !S2.valid || ready_i; sustain one request per cycle.
REQ-017 SHALL hold S2 outputs stable while valid_o && !ready_i.
REQ-018 SHALL take JAL/JALR always; BEQ on ==, BNE on !=, BLT signed <, BGE signed >=, BLTU unsigned <, BGEU unsigned >=.
REQ-019 SHALL compute target_o: JALR = (op1+sext(imm)) with bit0 cleared; all others = pc+sext(imm); all sums modulo 2^XLEN.
REQ-020 SHALL drive link_we_o=1 and link_o=pc+4 for JAL/JALR; link_we_o=0, link_o=0 for branches.
REQ-021 SHALL drive redirect_pc_o = taken_o ? target_o : pc+4.
REQ-022 SHALL assert mispredict_o when taken_o != pred_taken_i, or taken_o && target_o != pred_target_i.
REQ-023 SHALL assert misalign_o when taken_o && target_o[1]==1, and then force mispredict_o=0 and link_we_o=0.
REQ-024 SHALL on flush_i clear both stage valids next cycle, overriding a same-cycle accept; request presented with flush_i is dropped.
REQ-025 SHALL treat unlisted select_i codes as none: no taken_o, link_we_o=0, redirect_pc_o=pc+4.

Reset
REQ-026 SHALL, while rst high, clear S1/S2 valid, drive valid_o=0, and all data outputs 0; ready_o=1 the cycle after rst deasserts.
REQ-027 SHALL discard in-flight entries on reset mid-operation; rst overrides flush_i and valid_i.

Configuration
REQ-028 SHALL, with BEU_RVC_EN defined, add input is_rvc_i (1 bit), link and fall-through = pc+2 when is_rvc_i, and never assert misalign_o.
REQ-029 SHALL, without BEU_RVC_EN, have no is_rvc_i port, always use pc+4, and check misalignment per REQ-023.

Structure
REQ-030 SHALL take select_i encodings and a beu_op_e enum from the shared instr_op package; add the S1 stage struct typedef there.
REQ-031 SHALL instantiate one sub-module beu_cmp (combinational eq/lt/ltu flags, XLEN-parametrised).

Verification
REQ-032 BEQ op1=op2=5, pc=0x1000, imm=0x40, pred_taken=1, pred_target=0x1040 -> 2 cycles later taken=1, target=0x1040, mispredict=0.
REQ-033 BGE op1=-1, op2=-1 -> taken=1; BGEU op1=1, op2=0xFFFF_FFFF_FFFF_FFFF -> taken=0, redirect=pc+4, mispredict if pred_taken=1.
REQ-034 JALR op1=0x2001, imm=0x4, pc=0x100 -> target=0x2004, link=0x104, link_we=1.
REQ-035 JAL pc=0x100, imm=0x2 (non-RVC) -> misalign=1, link_we=0, mispredict=0; with BEU_RVC_EN, is_rvc=1 -> misalign=0, link=0x102.
REQ-036 Back-to-back 3 requests, ready_i low 2 cycles -> ready_o deasserts, outputs held, no loss or reorder; flush_i mid-stream -> valid_o=0 next cycle.
REQ-037 pc=0xFFFF_FFFF_FFFF_FFFC, JAL imm=0x8 -> target=0x4, link=0x0 (wrap).
